// File: rtl/imem_encoder_pkg.sv
// Shared defines for the instruction-memory encoder: request kinds, RV32I
// opcode/funct3/funct7 constants, controller states and small decode helpers.
package imem_encoder_pkg;

  // Request kind encoding carried on req_kind.
  typedef enum logic [3:0] {
    K_LUI    = 4'd0,
    K_AUIPC  = 4'd1,
    K_JAL    = 4'd2,
    K_JALR   = 4'd3,
    K_BRANCH = 4'd4,
    K_LOAD   = 4'd5,
    K_STORE  = 4'd6,
    K_OP_IMM = 4'd7,
    K_OP     = 4'd8
  } kind_e;

  // Session controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // RV32I major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 values with special meaning to the encoder.
  localparam logic [2:0] F3_JALR    = 3'd0;
  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;

  // funct7 values: base form and the inst[30] alternate (SUB/SRA/SRAI).
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Write address step and count ceiling.
  localparam logic [31:0] ADDR_STEP = 32'd4;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // True when funct3 selects an immediate shift (shamt form) in OP_IMM.
  function automatic logic is_imm_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

  // True when inst[30] may legally be set for this kind/funct3 pair.
  function automatic logic alt_allowed(input logic [3:0] kind, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (kind == K_OP && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) ok = 1'b1;
    if (kind == K_OP_IMM && f3 == F3_SRL_SRA) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/imem_encoder_if.sv
// Request, session-control and memory-write signals of the encoder.
// slave is the encoder's view; master is the view of whoever drives it.
interface imem_encoder_if;
  logic        start;
  logic [31:0] base_addr;
  logic        finish;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [2:0]  req_funct3;
  logic        req_alt;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;

  logic        imem_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;

  modport slave (
    input  start, base_addr, finish,
    input  req_valid, req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready,
    input  imem_ready,
    output imem_we, imem_addr, imem_wdata,
    output busy, done, err, count
  );

  modport master (
    output start, base_addr, finish,
    output req_valid, req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready,
    output imem_ready,
    input  imem_we, imem_addr, imem_wdata,
    input  busy, done, err, count
  );
endinterface

// File: rtl/imem_encoder_instr_encode.sv
// Purely combinational RV32I field packer: turns a decoded request into a
// 32-bit instruction word and flags requests that have no legal encoding.
module instr_encode
  import imem_encoder_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [6:0] funct7;

  // Pack fields per instruction format; illegal requests produce a zero word.
  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    funct7  = alt ? F7_ALT : F7_BASE;

    case (kind)
      K_LUI:   word = {imm[31:12], rd, OPC_LUI};
      K_AUIPC: word = {imm[31:12], rd, OPC_AUIPC};
      K_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      // JALR has only one funct3 encoding, so the request's value is not used.
      K_JALR:  word = {imm[11:0], rs1, F3_JALR, rd, OPC_JALR};
      K_BRANCH: begin
        if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      end
      K_LOAD: begin
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
        word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      end
      K_STORE: begin
        if (funct3 >= 3'd3) illegal = 1'b1;
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      end
      K_OP_IMM: begin
        if (is_imm_shift(funct3)) word = {funct7, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
        else                      word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      end
      K_OP:    word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
      default: illegal = 1'b1;
    endcase

    if (alt && !alt_allowed(kind, funct3)) illegal = 1'b1;
    if (illegal) word = '0;
  end

endmodule

// File: rtl/imem_encoder.sv
// Session controller for streaming encoded RV32I instructions into an
// instruction memory: one output stage, sequential addresses, write count,
// sticky illegal-request flag and an end-of-session pulse.
module imem_encoder
  import imem_encoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  imem_encoder_if.slave  bus
);

  state_e      state;
  state_e      state_next;

  logic        stage_valid;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] count_q;
  logic        err_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;
  logic        write_fire;
  logic        stage_empties;

  instr_encode u_encode (
    .kind    (bus.req_kind),
    .funct3  (bus.req_funct3),
    .alt     (bus.req_alt),
    .rd      (bus.req_rd),
    .rs1     (bus.req_rs1),
    .rs2     (bus.req_rs2),
    .imm     (bus.req_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // The stage can take a new word when empty or when its word leaves this cycle.
  assign write_fire    = stage_valid & bus.imem_ready;
  assign stage_empties = !stage_valid | bus.imem_ready;
  assign bus.req_ready = (state == ST_RUN) & stage_empties;
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.imem_we    = stage_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.err        = err_q;
  assign bus.count      = count_q;

  // State register; reset aborts any session at once.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start opens, finish drains, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.start)    state_next = ST_RUN;
      ST_RUN:   if (bus.finish)   state_next = ST_DRAIN;
      ST_DRAIN: if (stage_empties) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output stage, write address, count and error flag.
  // NOTE: the data word is reset along with its valid bit so imem_wdata reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        addr_q  <= bus.base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
      end

      if (write_fire) begin
        addr_q <= addr_q + ADDR_STEP;
        if (count_q != COUNT_MAX) count_q <= count_q + 16'd1;
      end

      if (accept && enc_illegal) err_q <= 1'b1;

      if (accept && !enc_illegal) begin
        stage_valid <= 1'b1;
        wdata_q     <= enc_word;
      end else if (write_fire) begin
        stage_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_encoder.sv
// Directed bench for imem_encoder: hand-encoded RV32I words, address/count
// bookkeeping, stall, illegal requests, wrap, finish overlap and mid-stall reset.
module tb_imem_encoder;
  import imem_encoder_pkg::*;

  logic clk;
  logic rst_n;

  imem_encoder_if bus ();

  imem_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int done_cnt;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Log every completed memory write and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_we && bus.imem_ready) begin
        got_addr.push_back(bus.imem_addr);
        got_data.push_back(bus.imem_wdata);
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_nwr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    got_addr.delete(); got_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic start_session(input logic [31:0] base);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = base;
    done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Present one request; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic a,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic fin);
    bit ok;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_kind   = k;
    bus.req_funct3 = f3;
    bus.req_alt    = a;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_imm    = imm;
    bus.finish     = fin;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.finish    = 1'b0;
  endtask

  task automatic end_session(input bit pulse_finish);
    bit seen;
    if (pulse_finish) begin
      @(posedge clk); #1 bus.finish = 1'b1;
      @(posedge clk); #1 bus.finish = 1'b0;
    end
    seen = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.finish = 1'b0;
    bus.req_valid = 1'b0; bus.req_kind = '0; bus.req_funct3 = '0; bus.req_alt = 1'b0;
    bus.req_rd = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_imm = '0;
    bus.imem_ready = 1'b1;

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_we",    32'(bus.imem_we),   32'd0);
    check("rst_addr",  bus.imem_addr,      32'd0);
    check("rst_wdata", bus.imem_wdata,     32'd0);
    check("rst_count", 32'(bus.count),     32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    #2 rst_n = 1'b1;

    // finish while idle does nothing
    @(posedge clk); #1 bus.finish = 1'b1;
    @(posedge clk); #1 bus.finish = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_finish_busy", 32'(bus.busy), 32'd0);
    check("idle_finish_done", 32'(done_cnt), 32'd0);

    // addi x1, x0, 5 at 0x100, visible the cycle after acceptance
    start_session(32'h100);
    @(negedge clk);
    check("run_busy",  32'(bus.busy),      32'd1);
    check("run_ready", 32'(bus.req_ready), 32'd1);
    send(K_OP_IMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    @(negedge clk);
    check("addi_we",    32'(bus.imem_we), 32'd1);
    check("addi_wdata", bus.imem_wdata,   32'h00500093);
    check("addi_addr",  bus.imem_addr,    32'h100);
    expect_wr(32'h100, 32'h00500093);
    end_session(1'b1);
    check("s1_count", 32'(bus.count), 32'd1);
    compare_log("s1");

    // lui + sub, with a start pulse during RUN that must be ignored
    start_session(32'h100);
    send(K_LUI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345000, 1'b0);
    @(posedge clk); #1 bus.start = 1'b1; bus.base_addr = 32'h900;
    @(posedge clk); #1 bus.start = 1'b0;
    send(K_OP, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    expect_wr(32'h100, 32'h12345137);
    expect_wr(32'h104, 32'h402081B3);
    end_session(1'b1);
    check("s2_count", 32'(bus.count), 32'd2);
    compare_log("s2");

    // sw / beq / jal / srai / jalr, with a 3-cycle memory stall on the store
    start_session(32'h200);
    send(K_STORE, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    bus.imem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d_we", s),    32'(bus.imem_we),   32'd1);
      check($sformatf("stall%0d_addr", s),  bus.imem_addr,      32'h200);
      check($sformatf("stall%0d_data", s),  bus.imem_wdata,     32'h0020A423);
      check($sformatf("stall%0d_ready", s), 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1 bus.imem_ready = 1'b1;
    send(K_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    send(K_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    send(K_OP_IMM, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0);
    send(K_JALR, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'h10, 1'b0);
    expect_wr(32'h200, 32'h0020A423);
    expect_wr(32'h204, 32'hFE208EE3);
    expect_wr(32'h208, 32'h008000EF);
    expect_wr(32'h20C, 32'h40335293);
    expect_wr(32'h210, 32'h010280E7);
    end_session(1'b1);
    check("s3_count", 32'(bus.count), 32'd5);
    compare_log("s3");

    // Illegal requests are consumed, not written, and set a sticky err
    start_session(32'h300);
    send(K_LOAD, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("ill_err",   32'(bus.err),     32'd1);
    check("ill_we",    32'(bus.imem_we), 32'd0);
    check("ill_count", 32'(bus.count),   32'd0);
    send(K_BRANCH, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0);
    send(K_OP_IMM, 3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    send(4'd9, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
    send(K_OP_IMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    expect_wr(32'h300, 32'h00500093);
    end_session(1'b1);
    check("s4_count", 32'(bus.count), 32'd1);
    check("s4_err",   32'(bus.err),   32'd1);
    compare_log("s4");

    // Address wrap; second request accepted together with finish
    start_session(32'hFFFFFFFC);
    @(negedge clk);
    check("s5_err_cleared", 32'(bus.err),   32'd0);
    check("s5_count_clear", 32'(bus.count), 32'd0);
    send(K_OP_IMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    send(K_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    expect_wr(32'hFFFFFFFC, 32'h00500093);
    expect_wr(32'h00000000, 32'h002081B3);
    end_session(1'b0);
    check("s5_count", 32'(bus.count), 32'd2);
    compare_log("s5");

    // Reset during a stalled write drops the strobe at once, nothing written
    start_session(32'h400);
    bus.imem_ready = 1'b0;
    send(K_OP_IMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    @(negedge clk);
    check("pre_rst_we", 32'(bus.imem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we",    32'(bus.imem_we), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),    32'd0);
    check("mid_rst_wdata", bus.imem_wdata,   32'd0);
    @(posedge clk); #1 rst_n = 1'b1; bus.imem_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_we",   32'(bus.imem_we), 32'd0);
    check("post_rst_addr", bus.imem_addr,    32'd0);
    compare_log("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
